// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and sizing helpers for the pixel-clock PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } seq_state_t;

  localparam int unsigned LOSS_W = 8;

  // Width of the single shared cycle counter: must hold the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned stable_cycles,
                                            input int unsigned timeout_cycles);
    int unsigned m;
    m = hold_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL control/status bundle between the lock sequencer (master) and the PLL/video side (slave).
interface pll_lock_sequencer_if #(
  parameter int unsigned MAX_RETRIES = 3
);
  import pll_seq_pkg::*;

  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  logic              PLL_LOCK;
  logic              RESTART;
  logic              PLL_RESETB;
  logic              VIDEO_RESETN;
  logic              CLK_READY;
  logic              FAULT;
  logic [RW-1:0]     RETRY_COUNT;
  logic [LOSS_W-1:0] LOSS_COUNT;

  modport master (
    input  PLL_LOCK, RESTART,
    output PLL_RESETB, VIDEO_RESETN, CLK_READY, FAULT, RETRY_COUNT, LOSS_COUNT
  );

  modport slave (
    output PLL_LOCK, RESTART,
    input  PLL_RESETB, VIDEO_RESETN, CLK_READY, FAULT, RETRY_COUNT, LOSS_COUNT
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / lock-loss sequencer for the SB_PLL40_CORE pixel-clock PLL (12 MHz domain).
// Define PLL_LOSS_COUNTER_EN to build the saturating lock-loss event counter.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES   = 12,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 120000,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input logic                  REFERENCECLK,
  input logic                  RESET,
  pll_lock_sequencer_if.master pll
);

  localparam int unsigned CW = cnt_width(RESET_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          cnt_clr;
  logic [RW-1:0] retry_q, retry_d;
  logic          lock_s;
  logic          presetb_q, vrstn_q, ready_q, fault_q;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (REFERENCECLK),
    .rst_n (RESET),
    .d     (pll.PLL_LOCK),
    .q     (lock_s)
  );

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_clr ? '0 : cnt_q + CW'(1);
      retry_q <= retry_d;
    end
  end

  // RESTART overrides every other transition; the counter restarts on any state change.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_clr = 1'b0;
    if (pll.RESTART) begin
      state_d = S_HOLD;
      retry_d = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RW'(1);
              state_d = S_HOLD;
            end else begin
              state_d = S_FAULT;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s) state_d = S_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          retry_d = '0;
          if (!lock_s) state_d = S_HOLD;
        end
        S_FAULT: ;
        default: state_d = S_HOLD;
      endcase
      if (state_d != state_q) cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      presetb_q <= 1'b0;
      vrstn_q   <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      presetb_q <= state_q inside {S_WAIT_LOCK, S_STABLE, S_RUN};
      vrstn_q   <= (state_q == S_RUN);
      ready_q   <= (state_q == S_RUN);
      fault_q   <= (state_q == S_FAULT);
    end
  end

  assign pll.PLL_RESETB   = presetb_q;
  assign pll.VIDEO_RESETN = vrstn_q;
  assign pll.CLK_READY    = ready_q;
  assign pll.FAULT        = fault_q;
  assign pll.RETRY_COUNT  = retry_q;

`ifdef PLL_LOSS_COUNTER_EN
  logic [LOSS_W-1:0] loss_q;
  logic              lock_loss;

  assign lock_loss = (state_q == S_RUN) && !pll.RESTART && !lock_s;

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) loss_q <= '0;
    else if (lock_loss && (loss_q != '1)) loss_q <= loss_q + LOSS_W'(1);
  end

  assign pll.LOSS_COUNT = loss_q;
`else
  assign pll.LOSS_COUNT = '0;
`endif

endmodule
